// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, gates the oversampled baud generator for the
// duration of a frame and samples start, data and stop bits at their centres.
module uart_rx_ctrl #(
  parameter int unsigned OVERSAMPLING = 8,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 os_tick,
  output logic                 gen_ena,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error
);

  localparam int unsigned TickW = $clog2(OVERSAMPLING);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLING / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLING - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic                 rx_meta_q, rx_s_q, rx_d_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;

  // Line idles high, so the synchroniser resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_out    <= '0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // os_tick deliberately ignored here; the generator restarts on enable.
          if (rx_d_q && !rx_s_q) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
            busy       <= 1'b1;
          end
        end
        StStart: begin
          if (os_tick) begin
            if (tick_cnt_q == TickHalf) begin
              if (!rx_s_q) begin
                state_q    <= StData;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StData: begin
          if (os_tick) begin
            if (tick_cnt_q == TickLast) begin
              shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + BitW'(1);
              if (bit_cnt_q == BitLast) begin
                state_q <= StStop;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StStop: begin
          if (os_tick) begin
            if (tick_cnt_q == TickLast) begin
              if (rx_s_q) begin
                data_out   <= shift_q;
                data_valid <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign gen_ena = busy;

endmodule
